osd_uart_line_buffer: RTL and testbench

- Character line buffer placed directly upstream of osd_dem_uart; feeds its out_char/out_valid/out_ready port.
- Accepts characters from the application side at any rate and stores them in a FIFO.
- Releases them to the debug UART one complete line at a time, so each host-side debug event carries whole lines instead of fragments.
- Also drains on full, on an explicit flush, or (optional) on idle timeout.

---
 rtl/osd_uart_line_buffer.sv | 120 ++++++++++++
 tb/tb_osd_uart_line_buffer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/osd_uart_line_buffer.sv
// Character FIFO that releases whole lines to osd_dem_uart, draining early on full or flush.
// Define OSD_UART_LINE_BUFFER_TIMEOUT_EN to also force out a partial line after TIMEOUT idle cycles.
module osd_uart_line_buffer #(
    parameter int         DEPTH     = 16,
    parameter logic [7:0] EOL       = 8'h0a,
    parameter int         LINE_MODE = 1,
    parameter int         TIMEOUT   = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_char,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [7:0]               out_char,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   lines
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {HOLD = 1'b0, DRAIN = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, lines_q;
    logic [AW:0] level_nxt, lines_nxt;
    logic        empty, full, push, pop, push_eol, pop_eol, draining, timeout_fire;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    // Gate with reset so the application never sees ready while the block is held.
    assign in_ready  = rst && !full;
    assign draining  = (LINE_MODE == 0) || (state == DRAIN);
    assign out_valid = draining && !empty;
    assign out_char  = mem[rd_ptr[AW-1:0]];

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign push_eol  = push && (in_char == EOL);
    assign pop_eol   = pop && (out_char == EOL);

    assign level     = wr_ptr - rd_ptr;
    assign lines     = lines_q;
    assign level_nxt = level + (AW+1)'(push) - (AW+1)'(pop);
    assign lines_nxt = lines_q + (AW+1)'(push_eol) - (AW+1)'(pop_eol);

`ifdef OSD_UART_LINE_BUFFER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] idle_cnt;
    logic          idle_run;

    assign idle_run     = (state == HOLD) && !empty && !push;
    assign timeout_fire = idle_run && (idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (!idle_run || state_nxt == DRAIN) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end
`else
    // No idle timer: a partial line waits for EOL, full or flush.
    assign timeout_fire = (TIMEOUT < 0);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            HOLD: begin
                // Look ahead at this cycle's push so a line is released the cycle after its EOL lands.
                if ((lines_nxt != '0) || (level_nxt == (AW+1)'(DEPTH)) ||
                    (flush && !empty) || timeout_fire) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop_eol || (empty && !push)) begin
                    state_nxt = HOLD;
                end
            end
            default: state_nxt = HOLD;
        endcase
        if (LINE_MODE == 0) begin
            state_nxt = DRAIN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            lines_q <= '0;
            state   <= HOLD;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            lines_q <= lines_nxt;
            state   <= state_nxt;
        end
    end

    // Character storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_char;
        end
    end

endmodule

// File: tb/tb_osd_uart_line_buffer.sv
// Scoreboard bench for osd_uart_line_buffer (DEPTH 16, TIMEOUT 8).
module tb_osd_uart_line_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_char;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [7:0] out_char;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] level;
    logic [4:0] lines;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] msg[13] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h57,
                            8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21, 8'h0a};

    osd_uart_line_buffer #(.DEPTH(16), .EOL(8'h0a), .LINE_MODE(1), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .in_char(in_char), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .lines(lines)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b need 0", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b need 0", out_valid); else pass_cnt++;
        total_cnt++; if (level !== 5'd0) $display("FAIL rst_level: got %0d need 0", level); else pass_cnt++;
        total_cnt++; if (lines !== 5'd0) $display("FAIL rst_lines: got %0d need 0", lines); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready: got %b need 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rel_out_valid: got %b need 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_line();
        logic [7:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            total_cnt++; if (out_valid !== 1'b0) $display("FAIL line_hold[%0d]: out_valid %b need 0", i, out_valid); else pass_cnt++;
            in_valid = 1'b1; in_char = msg[i]; exp_q.push_back(msg[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int j = 0; j < 13; j++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL line_valid[%0d]: got %b need 1", j, out_valid); else pass_cnt++;
            total_cnt++; if (out_char !== e) $display("FAIL line_char[%0d]: got %h need %h", j, out_char, e); else pass_cnt++;
            if (j == 12) begin
                total_cnt++; if (lines !== 5'd1) $display("FAIL line_lines_pre: got %0d need 1", lines); else pass_cnt++;
            end
            @(negedge clk);
        end
        total_cnt++; if (lines !== 5'd0) $display("FAIL line_lines_post: got %0d need 0", lines); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL line_end_valid: got %b need 0", out_valid); else pass_cnt++;
        total_cnt++; if (level !== 5'd0) $display("FAIL line_end_level: got %0d need 0", level); else pass_cnt++;
    endtask

    task automatic test_flush();
        logic [7:0] e;
`ifdef OSD_UART_LINE_BUFFER_TIMEOUT_EN
        int wait_cycles = 5;
`else
        int wait_cycles = 50;
`endif
        out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b1; in_char = 8'h48; exp_q.push_back(8'h48);
        @(negedge clk); in_valid = 1'b1; in_char = 8'h69; exp_q.push_back(8'h69);
        for (int c = 0; c < wait_cycles; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_hold[%0d]: out_valid %b need 0", c, out_valid); else pass_cnt++;
        end
        total_cnt++; if (level !== 5'd2) $display("FAIL flush_level: got %0d need 2", level); else pass_cnt++;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int j = 0; j < 2; j++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL flush_valid[%0d]: got %b need 1", j, out_valid); else pass_cnt++;
            total_cnt++; if (out_char !== e) $display("FAIL flush_char[%0d]: got %h need %h", j, out_char, e); else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_end_valid: got %b need 0", out_valid); else pass_cnt++;
        total_cnt++; if (level !== 5'd0) $display("FAIL flush_end_level: got %0d need 0", level); else pass_cnt++;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk); @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_empty_drop: out_valid %b need 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_full();
        logic [7:0] e;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            total_cnt++; if (in_ready !== 1'b1) $display("FAIL full_ready_pre[%0d]: got %b need 1", i, in_ready); else pass_cnt++;
            in_valid = 1'b1; in_char = 8'h30 + 8'(i); exp_q.push_back(8'h30 + 8'(i));
        end
        @(negedge clk);
        in_char = 8'h5a;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL full_ready: got %b need 0", in_ready); else pass_cnt++;
        total_cnt++; if (level !== 5'd16) $display("FAIL full_level: got %0d need 16", level); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL full_out_valid: got %b need 1", out_valid); else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++; if (level !== 5'd16) $display("FAIL full_blocked_level: got %0d need 16", level); else pass_cnt++;
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            if (j == 1) begin
                total_cnt++; if (in_ready !== 1'b1) $display("FAIL full_ready_after_pop: got %b need 1", in_ready); else pass_cnt++;
                total_cnt++; if (level !== 5'd15) $display("FAIL full_level_after_pop: got %0d need 15", level); else pass_cnt++;
            end
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL full_valid[%0d]: got %b need 1", j, out_valid); else pass_cnt++;
            total_cnt++; if (out_char !== e) $display("FAIL full_char[%0d]: got %h need %h", j, out_char, e); else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++; if (level !== 5'd0) $display("FAIL full_end_level: got %0d need 0", level); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat[4] = '{8'h61, 8'h0a, 8'h62, 8'h0a};
        logic       exp_v[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [4:0] exp_l[6] = '{5'd2, 5'd2, 5'd1, 5'd1, 5'd1, 5'd0};
        logic [7:0] e;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_char = pat[i]; exp_q.push_back(pat[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            total_cnt++; if (out_valid !== exp_v[k]) $display("FAIL b2b_valid[%0d]: got %b need %b", k, out_valid, exp_v[k]); else pass_cnt++;
            total_cnt++; if (lines !== exp_l[k]) $display("FAIL b2b_lines[%0d]: got %0d need %0d", k, lines, exp_l[k]); else pass_cnt++;
            if (out_valid === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                total_cnt++; if (out_char !== e) $display("FAIL b2b_char[%0d]: got %h need %h", k, out_char, e); else pass_cnt++;
            end
            @(negedge clk);
        end
        total_cnt++; if (exp_q.size() != 0) $display("FAIL b2b_left: got %0d need 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_char = msg[i]; exp_q.push_back(msg[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            total_cnt++; if (out_char !== e || out_valid !== 1'b1) $display("FAIL mid_char[%0d]: got %h/%b need %h/1", j, out_char, out_valid, e); else pass_cnt++;
            @(negedge clk);
        end
        rst = 1'b0;
        exp_q.delete();
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b need 0", out_valid); else pass_cnt++;
        total_cnt++; if (level !== 5'd0) $display("FAIL mid_rst_level: got %0d need 0", level); else pass_cnt++;
        total_cnt++; if (lines !== 5'd0) $display("FAIL mid_rst_lines: got %0d need 0", lines); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL mid_rst_ready: got %b need 0", in_ready); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_after[%0d]: out_valid %b need 0", c, out_valid); else pass_cnt++;
        end
        total_cnt++; if (level !== 5'd0) $display("FAIL mid_after_level: got %0d need 0", level); else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic exp_v;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_char = 8'h41; exp_q.push_back(8'h41);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
`ifdef OSD_UART_LINE_BUFFER_TIMEOUT_EN
            exp_v = (n == 9);
`else
            exp_v = 1'b0;
`endif
            total_cnt++; if (out_valid !== exp_v) $display("FAIL timeout_valid[%0d]: got %b need %b", n, out_valid, exp_v); else pass_cnt++;
            if (exp_v) begin
                total_cnt++; if (out_char !== exp_q[0]) $display("FAIL timeout_char: got %h need %h", out_char, exp_q[0]); else pass_cnt++;
                void'(exp_q.pop_front());
            end
        end
`ifndef OSD_UART_LINE_BUFFER_TIMEOUT_EN
        total_cnt++; if (level !== 5'd1) $display("FAIL timeout_wait_level: got %0d need 1", level); else pass_cnt++;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total_cnt++; if (out_char !== 8'h41 || out_valid !== 1'b1) $display("FAIL timeout_flush: got %h/%b need 41/1", out_char, out_valid); else pass_cnt++;
        void'(exp_q.pop_front());
        @(negedge clk);
`endif
        total_cnt++; if (level !== 5'd0) $display("FAIL timeout_end_level: got %0d need 0", level); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b0; in_char = 8'h00; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        test_reset();
        test_line();
        test_flush();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
